// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, optional parity, stop bit.
// Each bit is held for CLKS_PER_BIT clocks; tx_line idles high.
module serial_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_line,
  output logic              busy,
  output logic              done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic          PAR_INV  = (PARITY_ODD != 0);
  localparam logic          HAS_PAR  = (PARITY_EN != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state;
  logic [CW-1:0]     cyc;
  logic [BW-1:0]     bitcnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nx;
  logic              par;
  logic              bit_end;

  assign bit_end  = (cyc == CYC_LAST);
  assign shreg_nx = shreg >> 1;
  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // tx_line is loaded with the next bit's value on the boundary edge, so the
  // line changes in the same period the state does.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx_line <= 1'b1;
      done    <= 1'b0;
      cyc     <= '0;
      bitcnt  <= '0;
      shreg   <= '0;
      par     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE)
        cyc <= bit_end ? '0 : cyc + 1'b1;

      case (state)
        IDLE: begin
          cyc <= '0;
          if (tx_valid) begin
            shreg   <= tx_data;
            par     <= (^tx_data) ^ PAR_INV;
            state   <= START;
            tx_line <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            tx_line <= shreg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg <= shreg_nx;
            if (bitcnt == BIT_LAST) begin
              bitcnt <= '0;
              if (HAS_PAR) begin
                state   <= PARITY;
                tx_line <= par;
              end else begin
                state   <= STOP;
                tx_line <= 1'b1;
              end
            end else begin
              bitcnt  <= bitcnt + 1'b1;
              tx_line <= shreg_nx[0];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state   <= STOP;
            tx_line <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            state   <= IDLE;
            tx_line <= 1'b1;
            done    <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          tx_line <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: per-period expected line/done/ready/busy values are
// queued when a frame is requested and compared one period at a time.
module tb_serial_frame_tx;

  typedef struct packed {
    logic line;
    logic done;
    logic ready;
    logic busy;
  } exp_t;

  logic       clk;
  logic [2:0] rst;
  logic [2:0] tx_valid;
  logic [7:0] tx_data [3];
  logic [2:0] tx_ready;
  logic [2:0] tx_line;
  logic [2:0] busy;
  logic [2:0] done;

  int unsigned checks;
  int unsigned failures;
  exp_t        sb [$];

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .tx_line(tx_line[0]), .busy(busy[0]), .done(done[0]));

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .tx_line(tx_line[1]), .busy(busy[1]), .done(done[1]));

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) u_dut2 (
    .clk(clk), .rst(rst[2]), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .tx_line(tx_line[2]), .busy(busy[2]), .done(done[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, act, exp);
    end
  endtask

  // Expected frame built bit by bit: start, data LSB first, parity, stop, then the done period.
  task automatic push_frame(input logic [7:0] data, input int unsigned cpb,
                            input bit pen, input bit podd);
    logic bits [$];
    bits.push_back(1'b0);
    for (int unsigned i = 0; i < 8; i++) bits.push_back(data[i]);
    if (pen) bits.push_back((^data) ^ podd);
    bits.push_back(1'b1);
    foreach (bits[k])
      for (int unsigned c = 0; c < cpb; c++)
        sb.push_back('{line: bits[k], done: 1'b0, ready: 1'b0, busy: 1'b1});
    sb.push_back('{line: 1'b1, done: 1'b1, ready: 1'b1, busy: 1'b0});
  endtask

  // One period: sample after the edge, compare against the scoreboard (idle when empty).
  task automatic cycle(input int d, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() != 0) e = sb.pop_front();
    else e = '{line: 1'b1, done: 1'b0, ready: 1'b1, busy: 1'b0};
    chk($sformatf("%s.line", name), tx_line[d], e.line);
    chk($sformatf("%s.done", name), done[d], e.done);
    chk($sformatf("%s.ready", name), tx_ready[d], e.ready);
    chk($sformatf("%s.busy", name), busy[d], e.busy);
  endtask

  task automatic run(input int d, input int unsigned n, input string name);
    for (int unsigned i = 0; i < n; i++) cycle(d, name);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 3'b111;
    tx_valid = 3'b111;
    for (int i = 0; i < 3; i++) tx_data[i] = 8'hA5;

    // Reset held with a pending request: nothing starts.
    run(0, 2, "reset");
    rst      = 3'b000;
    tx_valid = 3'b000;
    run(0, 2, "post_reset");

    // Single default frame 0xA5 (even parity 0).
    tx_data[0] = 8'hA5; tx_valid[0] = 1'b1;
    push_frame(8'hA5, 4, 1'b1, 1'b0);
    run(0, 1, "a5");
    tx_valid[0] = 1'b0;
    run(0, 47, "a5");

    // Back-to-back: valid held across the done period.
    tx_data[0] = 8'h3C; tx_valid[0] = 1'b1;
    push_frame(8'h3C, 4, 1'b1, 1'b0);
    push_frame(8'hFF, 4, 1'b1, 1'b0);
    run(0, 1, "b2b");
    tx_data[0] = 8'hFF;
    run(0, 45, "b2b");
    tx_valid[0] = 1'b0;
    run(0, 47, "b2b2");

    // Data changes and a stray request mid-frame have no effect.
    tx_data[0] = 8'hA5; tx_valid[0] = 1'b1;
    push_frame(8'hA5, 4, 1'b1, 1'b0);
    run(0, 1, "stab");
    tx_valid[0] = 1'b0;
    tx_data[0]  = 8'h00;
    run(0, 8, "stab");
    tx_valid[0] = 1'b1;
    run(0, 1, "stab");
    tx_valid[0] = 1'b0;
    run(0, 38, "stab");

    // Reset asserted during period 20 abandons the frame without done.
    tx_data[0] = 8'h5A; tx_valid[0] = 1'b1;
    push_frame(8'h5A, 4, 1'b1, 1'b0);
    run(0, 1, "mid");
    tx_valid[0] = 1'b0;
    run(0, 19, "mid");
    rst[0] = 1'b1;
    sb.delete();
    run(0, 1, "mid_rst");
    rst[0] = 1'b0;
    run(0, 2, "mid_idle");
    tx_data[0] = 8'h81; tx_valid[0] = 1'b1;
    push_frame(8'h81, 4, 1'b1, 1'b0);
    run(0, 1, "x81");
    tx_valid[0] = 1'b0;
    run(0, 46, "x81");

    // Odd parity of 0x00 is 1.
    run(1, 1, "odd_idle");
    tx_data[1] = 8'h00; tx_valid[1] = 1'b1;
    push_frame(8'h00, 4, 1'b1, 1'b1);
    run(1, 1, "odd");
    tx_valid[1] = 1'b0;
    run(1, 46, "odd");

    // No parity, one clock per bit.
    run(2, 1, "np_idle");
    tx_data[2] = 8'h01; tx_valid[2] = 1'b1;
    push_frame(8'h01, 1, 1'b0, 1'b0);
    run(2, 1, "np");
    tx_valid[2] = 1'b0;
    run(2, 12, "np");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
